digit_serial_adder: RTL and testbench

DIGIT_SERIAL_ADDER -- requirements
Module: digit_serial_adder

---
 rtl/digit_serial_adder.sv | 145 ++++++++++++++
 tb/tb_digit_serial_adder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : digit_serial_adder
// Description : Adds two WIDTH-bit operands plus carry-in, DIGIT bits per
//               clock, LSB slice first. Valid/ready handshake on both sides;
//               one operation in flight at a time (IDLE -> RUN -> DONE).
// Revision    : 1.0 - initial release
// ============================================================================
module digit_serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    // Number of slices per operation and counter sizing (guarded so that a
    // bad parameter set reaches the fatal check instead of dividing by zero).
    localparam int c_rem      = (DIGIT >= 1) ? (WIDTH % DIGIT) : 0;
    localparam int c_n_digits = (DIGIT >= 1) ? (WIDTH / DIGIT) : 1;
    localparam int c_cnt_w    = (c_n_digits > 1) ? $clog2(c_n_digits) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_n_digits - 1);

    // Reject parameter sets that cannot be split into whole slices.
    generate
        if (WIDTH < 1 || DIGIT < 1 || c_rem != 0) begin : g_bad_params
            $fatal(1, "digit_serial_adder: WIDTH must be >= 1, DIGIT >= 1 and WIDTH a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;      // running carry between slices
    logic [WIDTH-1:0]   r_acc;        // partial sum being assembled
    logic [WIDTH-1:0]   r_sum;        // published result, stable between completions
    logic               r_carry_out;
    logic               r_ovf;
    logic               r_in_ready;
    logic               r_out_valid;

    logic [DIGIT:0]     w_slice;
    logic [WIDTH-1:0]   w_next_acc;
    logic               w_cin_msb;
    logic               w_ovf;

    // Current slice: low DIGIT bits of each operand shift register plus carry.
    assign w_slice = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, r_carry};

    // Carry into the top bit of the slice, recovered from that bit's sum.
    // On the final slice this is the carry into bit WIDTH-1.
    assign w_cin_msb = w_slice[DIGIT-1] ^ r_a[DIGIT-1] ^ r_b[DIGIT-1];
    assign w_ovf     = w_cin_msb ^ w_slice[DIGIT];

    // New slice enters the accumulator from the MSB end.
    generate
        if (DIGIT == WIDTH) begin : g_acc_single
            assign w_next_acc = w_slice[DIGIT-1:0];
        end else begin : g_acc_shift
            assign w_next_acc = {w_slice[DIGIT-1:0], r_acc[WIDTH-1:DIGIT]};
        end
    endgenerate

    // Control FSM and datapath; handshake outputs registered with the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_acc       <= '0;
            r_sum       <= '0;
            r_carry_out <= 1'b0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_carry    <= cin;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_carry <= w_slice[DIGIT];
                    r_acc   <= w_next_acc;
                    r_cnt   <= r_cnt + c_cnt_w'(1);
                    if (r_cnt == c_last) begin
                        r_sum       <= w_next_acc;
                        r_carry_out <= w_slice[DIGIT];
                        r_ovf       <= w_ovf;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign carry     = r_carry_out;
    assign overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_digit_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_digit_serial_adder
// Description : Self-checking bench for digit_serial_adder. Three instances
//               (WIDTH=8 with DIGIT=1, 4 and 8) share one clock; expected
//               results are queued when operands are issued and popped when
//               the result appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_digit_serial_adder;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n     [3];
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [W-1:0] a_s       [3];
    logic [W-1:0] b_s       [3];
    logic         cin_s     [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [W-1:0] sum_s     [3];
    logic         carry_s   [3];
    logic         ovf_s     [3];

    int n_of [3] = '{8, 2, 1};

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         k;
        logic [7:0] s;
        logic       c;
        logic       o;
    } exp_t;

    exp_t sbq[$];

    digit_serial_adder #(.WIDTH(W), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a_s[0]), .b(b_s[0]), .cin(cin_s[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .sum(sum_s[0]), .carry(carry_s[0]), .overflow(ovf_s[0])
    );

    digit_serial_adder #(.WIDTH(W), .DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a_s[1]), .b(b_s[1]), .cin(cin_s[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .sum(sum_s[1]), .carry(carry_s[1]), .overflow(ovf_s[1])
    );

    digit_serial_adder #(.WIDTH(W), .DIGIT(8)) u_d8 (
        .clk(clk), .rst_n(rst_n[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a_s[2]), .b(b_s[2]), .cin(cin_s[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .sum(sum_s[2]), .carry(carry_s[2]), .overflow(ovf_s[2])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset with in_valid and out_ready also high: reset must win.
    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0; in_valid[k] = 1'b1; out_ready[k] = 1'b1;
            a_s[k] = 8'h12; b_s[k] = 8'h34; cin_s[k] = 1'b1;
        end
        tick(); tick();
        for (int k = 0; k < 3; k++) begin
            in_valid[k] = 1'b0; out_ready[k] = 1'b0; rst_n[k] = 1'b1;
            checks++;
            if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 || sum_s[k] !== 8'h00
                || carry_s[k] !== 1'b0 || ovf_s[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset inst%0d: in_ready=%b out_valid=%b sum=%h carry=%b ovf=%b, required 1 0 00 0 0",
                         k, in_ready[k], out_valid[k], sum_s[k], carry_s[k], ovf_s[k]);
            end
        end
    endtask

    // Issue one operation on instance k, optionally scrambling operands and
    // raising in_valid during RUN, and holding out_ready low for hold cycles.
    task automatic run_op(input int k, input logic [7:0] av, input logic [7:0] bv,
                          input logic ci, input int hold, input bit scramble);
        exp_t       e;
        exp_t       got;
        int         edges;
        logic [8:0] full;
        logic [7:0] s0;
        logic       c0;
        logic       o0;
        full = {1'b0, av} + {1'b0, bv} + {8'h00, ci};
        e.k = k; e.s = full[7:0]; e.c = full[8];
        e.o = (av[7] == bv[7]) && (full[7] != av[7]);

        edges = 0;
        while (in_ready[k] !== 1'b1 && edges < 50) begin tick(); edges++; end
        checks++;
        if (in_ready[k] !== 1'b1) begin
            errors++;
            $display("FAIL ready_wait inst%0d: in_ready=%b after %0d cycles, required 1", k, in_ready[k], edges);
            return;
        end

        a_s[k] = av; b_s[k] = bv; cin_s[k] = ci; in_valid[k] = 1'b1;
        out_ready[k] = (hold == 0);
        sbq.push_back(e);
        tick();
        in_valid[k] = 1'b0;
        if (scramble) begin
            a_s[k] = ~av; b_s[k] = bv ^ 8'h5A; cin_s[k] = ~ci; in_valid[k] = 1'b1;
        end

        edges = 0;
        while (out_valid[k] !== 1'b1 && edges < 50) begin tick(); edges++; end
        in_valid[k] = 1'b0;
        got = sbq.pop_front();
        checks++;
        if (out_valid[k] !== 1'b1) begin
            errors++;
            $display("FAIL done_wait inst%0d: out_valid=%b after %0d cycles, required 1", k, out_valid[k], edges);
            return;
        end
        checks++;
        if (edges != n_of[k]) begin
            errors++;
            $display("FAIL latency inst%0d: %0d edges, required %0d", k, edges, n_of[k]);
        end
        checks++;
        if (sum_s[k] !== got.s || carry_s[k] !== got.c || ovf_s[k] !== got.o) begin
            errors++;
            $display("FAIL result inst%0d a=%h b=%h cin=%b: sum=%h carry=%b ovf=%b, required %h %b %b",
                     k, av, bv, ci, sum_s[k], carry_s[k], ovf_s[k], got.s, got.c, got.o);
        end
        checks++;
        if (in_ready[k] !== 1'b0) begin
            errors++;
            $display("FAIL ready_in_done inst%0d: in_ready=%b, required 0", k, in_ready[k]);
        end

        s0 = sum_s[k]; c0 = carry_s[k]; o0 = ovf_s[k];
        for (int i = 0; i < hold; i++) begin
            tick();
            checks++;
            if (out_valid[k] !== 1'b1 || sum_s[k] !== s0 || carry_s[k] !== c0 || in_ready[k] !== 1'b0) begin
                errors++;
                $display("FAIL backpressure inst%0d cycle %0d: out_valid=%b sum=%h carry=%b in_ready=%b, required 1 %h %b 0",
                         k, i, out_valid[k], sum_s[k], carry_s[k], in_ready[k], s0, c0);
            end
        end

        out_ready[k] = 1'b1;
        tick();
        out_ready[k] = 1'b0;
        checks++;
        if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0) begin
            errors++;
            $display("FAIL release inst%0d: in_ready=%b out_valid=%b, required 1 0", k, in_ready[k], out_valid[k]);
        end
        checks++;
        if (sum_s[k] !== s0 || carry_s[k] !== c0 || ovf_s[k] !== o0) begin
            errors++;
            $display("FAIL result_retained inst%0d: sum=%h carry=%b ovf=%b, required %h %b %b",
                     k, sum_s[k], carry_s[k], ovf_s[k], s0, c0, o0);
        end
    endtask

    task automatic test_directed();
        run_op(0, 8'hFF, 8'h01, 1'b0, 0, 1'b0);   // wrap to zero, carry out
        run_op(0, 8'h7F, 8'h01, 1'b0, 0, 1'b0);   // signed overflow, no carry
        run_op(1, 8'hA5, 8'h5A, 1'b1, 0, 1'b0);   // DIGIT=4 carry ripple across slices
        run_op(1, 8'h80, 8'h80, 1'b0, 0, 1'b0);   // negative overflow with carry
        run_op(2, 8'hFF, 8'hFF, 1'b1, 0, 1'b0);   // single-slice case
        run_op(2, 8'h40, 8'h40, 1'b0, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_op(0, 8'h3C, 8'h4D, 1'b1, 5, 1'b0);
        run_op(1, 8'hC8, 8'h9B, 1'b0, 5, 1'b0);
    endtask

    task automatic test_operand_change();
        run_op(0, 8'h12, 8'h34, 1'b0, 0, 1'b1);
        run_op(1, 8'hF0, 8'h0F, 1'b1, 1, 1'b1);
        run_op(2, 8'h55, 8'hAA, 1'b0, 0, 1'b1);
    endtask

    // Reset on the third RUN edge of a DIGIT=1 operation.
    task automatic test_reset_mid();
        int seen;
        int edges;
        edges = 0;
        while (in_ready[0] !== 1'b1 && edges < 50) begin tick(); edges++; end
        a_s[0] = 8'hFF; b_s[0] = 8'h01; cin_s[0] = 1'b0;
        in_valid[0] = 1'b1; out_ready[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        tick(); tick();
        rst_n[0] = 1'b0;
        tick();
        rst_n[0] = 1'b1;
        checks++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || sum_s[0] !== 8'h00 || carry_s[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: in_ready=%b out_valid=%b sum=%h carry=%b, required 1 0 00 0",
                     in_ready[0], out_valid[0], sum_s[0], carry_s[0]);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid[0] === 1'b1) seen++;
        end
        out_ready[0] = 1'b0;
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_mid_no_valid: out_valid seen %0d cycles, required 0", seen);
        end
    endtask

    // in_valid and out_ready held high: acceptances spaced N+2 cycles apart.
    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) begin
            int last;
            int gaps;
            int edges;
            a_s[k] = 8'h69; b_s[k] = 8'h96; cin_s[k] = 1'b1;
            in_valid[k] = 1'b1; out_ready[k] = 1'b1;
            last = -1; gaps = 0;
            for (int t = 0; t < 3 * (n_of[k] + 2) + 1; t++) begin
                if (in_ready[k] === 1'b1) begin
                    if (last >= 0) begin
                        gaps++;
                        checks++;
                        if (t - last != n_of[k] + 2) begin
                            errors++;
                            $display("FAIL throughput inst%0d: gap %0d cycles, required %0d", k, t - last, n_of[k] + 2);
                        end
                    end
                    last = t;
                end
                tick();
            end
            checks++;
            if (gaps < 2) begin
                errors++;
                $display("FAIL throughput_count inst%0d: %0d intervals, required >= 2", k, gaps);
            end
            in_valid[k] = 1'b0;
            edges = 0;
            while (in_ready[k] !== 1'b1 && edges < 30) begin tick(); edges++; end
            out_ready[k] = 1'b0;
            checks++;
            if (sum_s[k] !== 8'h00 || carry_s[k] !== 1'b1 || ovf_s[k] !== 1'b0) begin
                errors++;
                $display("FAIL b2b_result inst%0d: sum=%h carry=%b ovf=%b, required 00 1 0",
                         k, sum_s[k], carry_s[k], ovf_s[k]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 3; k++) begin
                run_op(k, 8'($urandom), 8'($urandom), 1'($urandom),
                       int'($urandom_range(0, 2)), 1'($urandom));
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0; in_valid[k] = 1'b0; out_ready[k] = 1'b0;
            a_s[k] = '0; b_s[k] = '0; cin_s[k] = 1'b0;
        end
        test_reset();
        test_directed();
        test_backpressure();
        test_operand_change();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
